// File: rtl/tlk2711_pkg.sv
// Shared encodings, word classes and link states for the TLK2711 receive link monitor.
package tlk2711_pkg;

  localparam logic [15:0] K_IDLE = 16'hBCC5;
  localparam logic [15:0] K_SOF  = 16'hFBFB;
  localparam logic [15:0] K_EOF  = 16'hFDFD;
  localparam logic [15:0] K_ERR  = 16'hFEFE;

  typedef enum logic [2:0] {
    WC_IDLE    = 3'd0,
    WC_SOF     = 3'd1,
    WC_EOF     = 3'd2,
    WC_ERR     = 3'd3,
    WC_DATA    = 3'd4,
    WC_INVALID = 3'd5
  } word_class_e;

  typedef enum logic [1:0] {
    ST_LOS   = 2'd0,
    ST_LINK  = 2'd1,
    ST_FRAME = 2'd2
  } state_e;

  function automatic word_class_e classify(input logic kmsb, input logic klsb,
                                           input logic [15:0] rxd);
    word_class_e wc;
    case ({kmsb, klsb})
      2'b00: wc = WC_DATA;
      2'b10: wc = (rxd == K_IDLE) ? WC_IDLE : WC_INVALID;
      2'b11: begin
        if (rxd == K_SOF)      wc = WC_SOF;
        else if (rxd == K_EOF) wc = WC_EOF;
        else if (rxd == K_ERR) wc = WC_ERR;
        else                   wc = WC_INVALID;
      end
      default: wc = WC_INVALID;
    endcase
    return wc;
  endfunction

endpackage

// File: rtl/tlk2711_sat_cnt.sv
// Saturating statistics counter; clear wins over a simultaneous increment.
module tlk2711_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tlk2711_rx_link_mon.sv
// TLK2711 receive link monitor: sync qualification, SOF/EOF framing and link statistics.
module tlk2711_rx_link_mon #(
  parameter int SYNC_CNT  = 8,
  parameter int LOSS_CNT  = 4,
  parameter int MAX_LEN   = 4096,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          i_2711_rxd,
  input  logic                 i_2711_rkmsb,
  input  logic                 i_2711_rklsb,
  input  logic                 i_clear_cnt,
  output logic                 o_link_up,
  output logic                 o_loss_irq,
  output logic [15:0]          o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_sof,
  output logic                 o_rx_eof,
  output logic                 o_rx_err,
  output logic [15:0]          o_frame_len,
  output logic [CNT_WIDTH-1:0] o_frame_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt
);
  import tlk2711_pkg::*;

  localparam int SYNC_W = $clog2(SYNC_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);

  // Input stage; the clear request travels with the word so it lines up with that word's effects.
  logic [15:0]       rxd_q;
  logic              rkmsb_q, rklsb_q, clear_q;
  word_class_e       wc_s;
  state_e            state_d, state_q;
  logic [SYNC_W-1:0] sync_d, sync_q;
  logic [LOSS_W-1:0] loss_d, loss_q;
  logic [LEN_W-1:0]  len_d, len_q;
  logic [15:0]       len_sat_s;
  logic              sof_arm_d, sof_arm_q;
  logic              link_up_d, link_up_q;
  logic              loss_irq_d, loss_irq_q;
  logic [15:0]       rx_data_d, rx_data_q;
  logic              rx_valid_d, rx_valid_q;
  logic              rx_sof_d, rx_sof_q;
  logic              rx_eof_d, rx_eof_q;
  logic              rx_err_d, rx_err_q;
  logic [15:0]       frame_len_d, frame_len_q;
  logic              frame_inc_s, err_inc_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_q   <= 16'h0000;
      rkmsb_q <= 1'b0;
      rklsb_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      rxd_q   <= i_2711_rxd;
      rkmsb_q <= i_2711_rkmsb;
      rklsb_q <= i_2711_rklsb;
      clear_q <= i_clear_cnt;
    end
  end

  assign wc_s = classify(rkmsb_q, rklsb_q, rxd_q);

  always_comb begin
    if (32'(len_q) > 32'h0000_FFFF) len_sat_s = 16'hFFFF;
    else                            len_sat_s = 16'(len_q);
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = sync_q;
    loss_d      = loss_q;
    len_d       = len_q;
    sof_arm_d   = sof_arm_q;
    link_up_d   = link_up_q;
    loss_irq_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_sof_d    = 1'b0;
    rx_eof_d    = 1'b0;
    rx_err_d    = 1'b0;
    frame_len_d = frame_len_q;
    frame_inc_s = 1'b0;
    err_inc_s   = 1'b0;
    case (state_q)
      ST_LOS: begin
        loss_d = '0;
        if (wc_s == WC_IDLE) begin
          if (sync_q == SYNC_W'(SYNC_CNT - 1)) begin
            sync_d    = '0;
            state_d   = ST_LINK;
            link_up_d = 1'b1;
          end else begin
            sync_d = sync_q + SYNC_W'(1);
          end
        end else begin
          sync_d = '0;
        end
      end
      ST_LINK, ST_FRAME: begin
        if ((wc_s == WC_ERR) || (wc_s == WC_INVALID)) begin
          // Isolated bad words are swallowed; only a full run drops the link.
          if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
            loss_d     = '0;
            sync_d     = '0;
            state_d    = ST_LOS;
            link_up_d  = 1'b0;
            loss_irq_d = 1'b1;
            err_inc_s  = 1'b1;
            if (state_q == ST_FRAME) begin
              rx_eof_d    = 1'b1;
              rx_err_d    = 1'b1;
              frame_len_d = len_sat_s;
            end else begin
              rx_eof_d = 1'b0;
            end
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end else if (state_q == ST_LINK) begin
          loss_d = '0;
          if (wc_s == WC_SOF) begin
            state_d   = ST_FRAME;
            len_d     = '0;
            sof_arm_d = 1'b1;
          end else begin
            state_d = ST_LINK;
          end
        end else begin
          loss_d = '0;
          case (wc_s)
            WC_DATA: begin
              if (len_q == LEN_W'(MAX_LEN)) begin
                rx_eof_d    = 1'b1;
                rx_err_d    = 1'b1;
                frame_len_d = len_sat_s;
                err_inc_s   = 1'b1;
                state_d     = ST_LINK;
              end else begin
                rx_valid_d = 1'b1;
                rx_data_d  = rxd_q;
                rx_sof_d   = sof_arm_q;
                sof_arm_d  = 1'b0;
                len_d      = len_q + LEN_W'(1);
              end
            end
            WC_EOF: begin
              rx_eof_d    = 1'b1;
              frame_len_d = len_sat_s;
              frame_inc_s = 1'b1;
              state_d     = ST_LINK;
            end
            WC_SOF: begin
              rx_eof_d    = 1'b1;
              rx_err_d    = 1'b1;
              frame_len_d = len_sat_s;
              err_inc_s   = 1'b1;
              len_d       = '0;
              sof_arm_d   = 1'b1;
            end
            WC_IDLE: begin
              rx_eof_d    = 1'b1;
              rx_err_d    = 1'b1;
              frame_len_d = len_sat_s;
              err_inc_s   = 1'b1;
              state_d     = ST_LINK;
            end
            default: state_d = state_q;
          endcase
        end
      end
      default: state_d = ST_LOS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOS;
      sync_q      <= '0;
      loss_q      <= '0;
      len_q       <= '0;
      sof_arm_q   <= 1'b0;
      link_up_q   <= 1'b0;
      loss_irq_q  <= 1'b0;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      frame_len_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      loss_q      <= loss_d;
      len_q       <= len_d;
      sof_arm_q   <= sof_arm_d;
      link_up_q   <= link_up_d;
      loss_irq_q  <= loss_irq_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_sof_q    <= rx_sof_d;
      rx_eof_q    <= rx_eof_d;
      rx_err_q    <= rx_err_d;
      frame_len_q <= frame_len_d;
    end
  end

  tlk2711_sat_cnt #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_q),
    .inc (frame_inc_s),
    .cnt (o_frame_cnt)
  );

  tlk2711_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear_q),
    .inc (err_inc_s),
    .cnt (o_err_cnt)
  );

  assign o_link_up   = link_up_q;
  assign o_loss_irq  = loss_irq_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_rx_sof    = rx_sof_q;
  assign o_rx_eof    = rx_eof_q;
  assign o_rx_err    = rx_err_q;
  assign o_frame_len = frame_len_q;

endmodule

// File: doc/tlk2711_rx_link_mon.md
Name: tlk2711_rx_link_mon

Overview:
- Receive-side stage directly downstream of the TLK2711 parallel receive pins (i_2711_rxd / rkmsb / rklsb).
- Qualifies link sync from idle ordered sets and delimits SOF/EOF frames into a 16-bit payload stream for the RX DMA write path.
- Maintains link/frame statistics and produces a single-cycle loss-of-sync interrupt pulse for the register block.

Parameters:
- SYNC_CNT, 8: consecutive idle words required to declare link up.
- LOSS_CNT, 4: consecutive invalid/error words required to declare link down.
- MAX_LEN, 4096: maximum payload words per frame; exceeding it is a frame error.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset; asynchronous assert, active-high.
- i_2711_rxd  in  16  receive word from the TLK2711.
- i_2711_rkmsb  in  1  K flag, upper byte.
- i_2711_rklsb  in  1  K flag, lower byte.
- i_clear_cnt  in  1  synchronous clear of all statistics counters.
- o_link_up  out  1  link synchronised.
- o_loss_irq  out  1  one-cycle pulse on link_up 1->0.
- o_rx_data  out  16  payload word.
- o_rx_valid  out  1  payload word valid.
- o_rx_sof  out  1  first payload word of a frame; coincides with o_rx_valid.
- o_rx_eof  out  1  frame end; may assert with o_rx_valid=0 (empty frame or abort).
- o_rx_err  out  1  frame error; valid only with o_rx_eof.
- o_frame_len  out  16  payload word count; valid only with o_rx_eof.
- o_frame_cnt  out  CNT_WIDTH  good frames received, saturating.
- o_err_cnt  out  CNT_WIDTH  errored frames plus loss events, saturating.

Behaviour:
- Word classes, decided from {rkmsb, rklsb, rxd}:
  - IDLE = 1,0,16'hBCC5
  - SOF = 1,1,16'hFBFB
  - EOF = 1,1,16'hFDFD
  - ERR = 1,1,16'hFEFE
  - DATA = 0,0,any
  - INVALID = every other combination.
- Register input word and flags once; classify from the registered copy. Every output is registered, so total latency from pin to output is 2 cycles.
- Reset: all outputs 0, state LOS, internal counters 0.
- State LOS:
  - Each IDLE increments the sync counter; any other class clears it.
  - When the counter reaches SYNC_CNT, go to LINK and set o_link_up=1.
- State LINK:
  - SOF: go to FRAME, clear length counter, arm the sof flag.
  - DATA, EOF, IDLE: ignored. A stray EOF does not increment o_err_cnt.
- State FRAME:
  - DATA: o_rx_valid=1, o_rx_data=word, o_rx_sof=armed flag (then clear flag), length+1.
  - EOF: o_rx_eof=1, o_frame_len=length, o_rx_err=0, o_frame_cnt+1, go to LINK.
  - SOF: abort current frame (o_rx_eof=1, o_rx_err=1, o_err_cnt+1), restart FRAME in the same cycle with length 0.
  - IDLE: abort current frame with err, go to LINK.
  - Length reaching MAX_LEN with another DATA word: that word is not forwarded; abort with err, go to LINK.
  - Empty frame (SOF then EOF): o_rx_eof=1, o_frame_len=0, o_rx_valid=0, counts as a good frame.
- Loss detection (LINK and FRAME):
  - Each ERR/INVALID word increments the loss counter; any valid class clears it. An isolated ERR inside FRAME is not forwarded and does not abort.
  - When the loss counter reaches LOSS_CNT: o_link_up=0, o_loss_irq=1 for one cycle, o_err_cnt+1, go to LOS.
  - If this happens in FRAME, also emit o_rx_eof=1, o_rx_err=1 in the same cycle. That abort adds no second o_err_cnt increment.
- Counters saturate at all-ones.
- i_clear_cnt has priority over a simultaneous increment; the result is 0.
- o_frame_len saturates at 16'hFFFF when MAX_LEN exceeds 65535.

Decomposition:
- Package tlk2711_pkg holds:
  - class encodings (IDLE, SOF, EOF, ERR K-codes) and the word-class enum;
  - state enum {LOS, LINK, FRAME}.
- Sub-module tlk2711_sat_cnt: saturating counter with clear and inc, instantiated for o_frame_cnt and o_err_cnt.

Test Plan:
- Reset, then 7 IDLE words -> o_link_up stays 0; 8th IDLE -> o_link_up=1 two cycles later.
- Link up; SOF, DATA 0x0001..0x0003, EOF -> three valid words with sof on 0x0001; eof with o_frame_len=3, o_rx_err=0; o_frame_cnt=1.
- In frame, second SOF after 2 DATA words -> eof+err with len 2, o_err_cnt=1; the next frame proceeds normally.
- Link up, then 4 consecutive ERR words mid-frame -> o_loss_irq pulses once; o_link_up=0; eof+err; o_err_cnt+1; SYNC_CNT IDLEs re-acquire the link.
- MAX_LEN=4; SOF plus 5 DATA words -> 4 words forwarded, eof+err with len 4; EOF arriving after returning to LINK is ignored.
- o_frame_cnt forced near all-ones, then 2 good frames -> holds all-ones; i_clear_cnt coincident with an EOF -> counter reads 0.
